// File: rtl/bram_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arb_pkg
// Description : Shared encodings and default sizes for the two-requester
//               BRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arb_pkg;

    // Default BRAM geometry and forced-revoke hold limit
    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_HOLD = 8192;

    // Arbiter state encoding; gnt is decoded directly from these values
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bram_port_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arb_rr
// Description : Two-input round-robin picker. ptr holds the index granted
//               last; on a tie the other index wins. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arb_rr
    import bram_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       any_valid
);

    // Lone requester wins outright; on a tie favour the one not granted last
    always_comb begin
        any_valid = |req;
        winner    = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~ptr;
            default: winner = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arb
// Description : Shares one BRAM port between two requesters. Job-level
//               round-robin grant, combinational port mux from the grant
//               state, and per-requester read-valid aligned to the 1-cycle
//               BRAM read latency.
//               Optional forced revoke: define BRAM_PORT_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arb
    import bram_port_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    input  logic [ADDR_W-1:0]   r0_addr,
    input  logic [DATA_W-1:0]   r0_wrdata,
    input  logic [DATA_W/8-1:0] r0_we,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [DATA_W-1:0]   r1_wrdata,
    input  logic [DATA_W/8-1:0] r1_we,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_valid,
    output logic [ADDR_W-1:0]   bram_addr,
    input  logic [DATA_W-1:0]   bram_rddata,
    output logic [DATA_W-1:0]   bram_wrdata,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [1:0]          timeout_err
);

    arb_state_t r_state;
    logic       r_ptr;
    logic [1:0] r_rd_valid;

    logic [1:0] w_req_eff;   // requests eligible for a new grant
    logic       w_win;
    logic       w_any;
    logic       w_revoke0;   // G0 forcibly handed to requester 1
    logic       w_revoke1;   // G1 forcibly handed to requester 0

`ifdef BRAM_PORT_ARB_TIMEOUT_EN
    localparam int                  c_HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD - 1);

    logic [c_HOLD_W-1:0] r_hold;
    logic [1:0]          r_mask;
    logic [1:0]          r_timeout_err;
    logic                w_hold_max;
    logic                w_enter;

    // A revoked requester stays ineligible until it has dropped req once
    always_comb begin
        w_req_eff  = req & ~r_mask;
        w_hold_max = (r_hold == c_HOLD_MAX);
        w_revoke0  = (r_state == ARB_G0) && req[0] && w_hold_max && w_req_eff[1];
        w_revoke1  = (r_state == ARB_G1) && req[1] && w_hold_max && w_req_eff[0];
        w_enter    = ((r_state == ARB_IDLE) && w_any)
                  || ((r_state == ARB_G0) && (!req[0] || w_revoke0) && w_req_eff[1])
                  || ((r_state == ARB_G1) && (!req[1] || w_revoke1) && w_req_eff[0]);
    end

    // Hold counter, revoke masks and sticky revoke flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold        <= '0;
            r_mask        <= 2'b00;
            r_timeout_err <= 2'b00;
        end else begin
            if (w_enter)
                r_hold <= '0;
            else if ((r_state != ARB_IDLE) && !w_hold_max)
                r_hold <= r_hold + 1'b1;
            r_mask[0]     <= (r_mask[0] & req[0]) | w_revoke0;
            r_mask[1]     <= (r_mask[1] & req[1]) | w_revoke1;
            r_timeout_err <= r_timeout_err | {w_revoke1, w_revoke0};
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_hold;

    // Grant is held until voluntary release; MAX_HOLD has no effect here
    always_comb begin
        w_req_eff     = req;
        w_revoke0     = 1'b0;
        w_revoke1     = 1'b0;
        w_unused_hold = (MAX_HOLD != 0);
    end

    assign timeout_err = 2'b00;
`endif

    bram_port_arb_rr u_rr (
        .req       (w_req_eff),
        .ptr       (r_ptr),
        .winner    (w_win),
        .any_valid (w_any)
    );

    // Grant FSM; pointer records the requester entered on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b1;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= w_win ? ARB_G1 : ARB_G0;
                        r_ptr   <= w_win;
                    end
                end
                ARB_G0: begin
                    if (!req[0] || w_revoke0) begin
                        if (w_req_eff[1]) begin
                            r_state <= ARB_G1;
                            r_ptr   <= 1'b1;
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                ARB_G1: begin
                    if (!req[1] || w_revoke1) begin
                        if (w_req_eff[0]) begin
                            r_state <= ARB_G0;
                            r_ptr   <= 1'b0;
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt = {r_state == ARB_G1, r_state == ARB_G0};

    // Port mux; write enables are also killed in the holder's release cycle
    always_comb begin
        bram_addr   = '0;
        bram_wrdata = '0;
        bram_we     = '0;
        case (r_state)
            ARB_G0: begin
                bram_addr   = r0_addr;
                bram_wrdata = r0_wrdata;
                bram_we     = req[0] ? r0_we : '0;
            end
            ARB_G1: begin
                bram_addr   = r1_addr;
                bram_wrdata = r1_wrdata;
                bram_we     = req[1] ? r1_we : '0;
            end
            default: ;
        endcase
    end

    // Read-valid follows each granted read cycle by one clock, matching BRAM latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 2'b00;
        end else begin
            r_rd_valid[0] <= (r_state == ARB_G0) && req[0] && (r0_we == '0);
            r_rd_valid[1] <= (r_state == ARB_G1) && req[1] && (r1_we == '0);
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = bram_rddata;

endmodule
`default_nettype wire
